// File: rtl/upgrade_spawner.sv
// -----------------------------------------------------------------------------
// upgrade_spawner
//
// Decides when and where the bullet-upgrade pickup appears. The block sits
// upstream of the pickup collision stage and advances once per video frame.
//
// Sequence: WAIT (spawn delay) -> PICK (LFSR-driven placement, with a centre
// fallback) -> ACTIVE (visible until collected or expired) -> back to WAIT.
// On every despawn a one-frame upgrade_clear pulse is issued. The top level
// ORs this pulse into the collision stage's reset so that was_collected
// re-arms.
//
// Ports:
//   frame_clk        in   1  frame clock, rising edge active
//   Reset            in   1  asynchronous reset, active-high
//   was_collected    in   1  latched collected flag from the collision stage
//   UpgradeX         out 10  pickup centre X (1000 while hidden)
//   UpgradeY         out 10  pickup centre Y (1000 while hidden)
//   Upgrade_Size     out 10  constant SIZE
//   upgrade_visible  out  1  pickup is drawn and collectable
//   upgrade_clear    out  1  one-frame pulse on the first WAIT frame
//   pickup_count     out  8  pickups collected, saturating at 255
// -----------------------------------------------------------------------------
module upgrade_spawner #(
    parameter int          SPAWN_DELAY = 300,
    parameter int          LIFETIME    = 600,
    parameter int          SIZE        = 4,
    parameter int          X_MIN       = 16,
    parameter int          X_MAX       = 623,
    parameter int          Y_MIN       = 16,
    parameter int          Y_MAX       = 463,
    parameter int          MAX_TRIES   = 8,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       was_collected,
    output logic [9:0] UpgradeX,
    output logic [9:0] UpgradeY,
    output logic [9:0] Upgrade_Size,
    output logic       upgrade_visible,
    output logic       upgrade_clear,
    output logic [7:0] pickup_count
);

    // Timer must hold the larger of the two reload values.
    localparam int TMAX = (SPAWN_DELAY > LIFETIME) ? SPAWN_DELAY : LIFETIME;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int TRW  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    localparam logic [TW-1:0]  WAIT_LOAD  = TW'(SPAWN_DELAY - 1);
    localparam logic [TW-1:0]  LIFE_LOAD  = (LIFETIME > 0) ? TW'(LIFETIME - 1) : {TW{1'b0}};
    localparam logic [TW-1:0]  TIMER_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0]  TIMER_ONE  = TW'(1);
    localparam logic [TRW-1:0] TRIES_LAST = TRW'(MAX_TRIES - 1);
    localparam logic [TRW-1:0] TRIES_ZERO = {TRW{1'b0}};
    localparam logic [TRW-1:0] TRIES_ONE  = TRW'(1);
    localparam logic           HAS_LIFE   = (LIFETIME != 0) ? 1'b1 : 1'b0;

    // An all-zero seed would lock the LFSR, so it is substituted.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    localparam logic [9:0]  PARK     = 10'd1000;
    localparam logic [9:0]  CENTRE_X = 10'd320;
    localparam logic [9:0]  CENTRE_Y = 10'd240;
    localparam logic [31:0] X_MIN_U  = 32'(X_MIN);
    localparam logic [31:0] X_MAX_U  = 32'(X_MAX);
    localparam logic [31:0] Y_MIN_U  = 32'(Y_MIN);
    localparam logic [31:0] Y_MAX_U  = 32'(Y_MAX);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_PICK   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Galois right-shift step with tap mask B400; never maps a non-zero value to 0.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    state_t         state_r, state_s;
    logic [TW-1:0]  timer_r, timer_s;
    logic [TRW-1:0] tries_r, tries_s;
    logic [15:0]    lfsr_r;
    logic [9:0]     x_s, y_s;
    logic           visible_s, clear_s;
    logic [7:0]     count_s;
    logic           place_s, fallback_s, despawn_s, collect_s;
    logic [9:0]     cand_x_s, cand_y_s;
    logic           cand_ok_s;

    assign Upgrade_Size = 10'(SIZE);

    // Candidate position taken straight from the current LFSR value.
    assign cand_x_s  = lfsr_r[9:0];
    assign cand_y_s  = {1'b0, lfsr_r[15:7]};
    assign cand_ok_s = ({22'd0, cand_x_s} >= X_MIN_U) && ({22'd0, cand_x_s} <= X_MAX_U) &&
                       ({22'd0, cand_y_s} >= Y_MIN_U) && ({22'd0, cand_y_s} <= Y_MAX_U);

    // State register plus all registered datapath and outputs.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_r         <= ST_WAIT;
            timer_r         <= WAIT_LOAD;
            tries_r         <= TRIES_ZERO;
            lfsr_r          <= SEED_EFF;
            UpgradeX        <= PARK;
            UpgradeY        <= PARK;
            upgrade_visible <= 1'b0;
            upgrade_clear   <= 1'b0;
            pickup_count    <= 8'd0;
        end else begin
            state_r         <= state_s;
            timer_r         <= timer_s;
            tries_r         <= tries_s;
            lfsr_r          <= lfsr_advance(lfsr_r);
            UpgradeX        <= x_s;
            UpgradeY        <= y_s;
            upgrade_visible <= visible_s;
            upgrade_clear   <= clear_s;
            pickup_count    <= count_s;
        end
    end

    // Next-state logic: sequencing, timer and retry counter.
    always_comb begin
        state_s    = state_r;
        timer_s    = timer_r;
        tries_s    = tries_r;
        place_s    = 1'b0;
        fallback_s = 1'b0;
        despawn_s  = 1'b0;
        collect_s  = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if (timer_r == TIMER_ZERO) begin
                    state_s = ST_PICK;
                    tries_s = TRIES_ZERO;
                end else begin
                    timer_s = timer_r - TIMER_ONE;
                end
            end
            ST_PICK: begin
                if (cand_ok_s) begin
                    state_s = ST_ACTIVE;
                    timer_s = LIFE_LOAD;
                    place_s = 1'b1;
                end else if (tries_r == TRIES_LAST) begin
                    state_s    = ST_ACTIVE;
                    timer_s    = LIFE_LOAD;
                    place_s    = 1'b1;
                    fallback_s = 1'b1;
                end else begin
                    tries_s = tries_r + TRIES_ONE;
                end
            end
            ST_ACTIVE: begin
                // Collection wins over a simultaneous expiry.
                if (was_collected) begin
                    state_s   = ST_WAIT;
                    timer_s   = WAIT_LOAD;
                    despawn_s = 1'b1;
                    collect_s = 1'b1;
                end else if (HAS_LIFE && (timer_r == TIMER_ZERO)) begin
                    state_s   = ST_WAIT;
                    timer_s   = WAIT_LOAD;
                    despawn_s = 1'b1;
                end else if (HAS_LIFE) begin
                    timer_s = timer_r - TIMER_ONE;
                end else begin
                    timer_s = timer_r;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a clean despawn.
                state_s   = ST_WAIT;
                timer_s   = WAIT_LOAD;
                tries_s   = TRIES_ZERO;
                despawn_s = 1'b1;
            end
        endcase
    end

    // Output next-values: placement, parking, clear pulse, saturating count.
    always_comb begin
        x_s       = UpgradeX;
        y_s       = UpgradeY;
        visible_s = upgrade_visible;
        clear_s   = despawn_s;
        count_s   = pickup_count;
        if (place_s) begin
            visible_s = 1'b1;
            x_s       = fallback_s ? CENTRE_X : cand_x_s;
            y_s       = fallback_s ? CENTRE_Y : cand_y_s;
        end else if (despawn_s) begin
            visible_s = 1'b0;
            x_s       = PARK;
            y_s       = PARK;
        end else begin
            visible_s = upgrade_visible;
        end
        if (collect_s && (pickup_count != 8'd255)) begin
            count_s = pickup_count + 8'd1;
        end else begin
            count_s = pickup_count;
        end
    end

endmodule

// File: tb/tb_upgrade_spawner.sv
// -----------------------------------------------------------------------------
// tb_upgrade_spawner
//
// Directed, self-checking bench for upgrade_spawner. A second instance with an
// impossible X window exercises the centre fallback. Placement expectations
// come from an independent LFSR model driven from the same reset.
// -----------------------------------------------------------------------------
module tb_upgrade_spawner;

    localparam int MAXT = 8;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic       was_collected = 1'b0;
    logic [9:0] ux, uy, usize;
    logic       uvis, uclr;
    logic [7:0] ucnt;

    logic       was_collected2 = 1'b0;
    logic [9:0] ux2, uy2, usize2;
    logic       uvis2, uclr2;
    logic [7:0] ucnt2;

    int total = 0;
    int bad   = 0;

    always #5 frame_clk = ~frame_clk;

    upgrade_spawner dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .was_collected  (was_collected),
        .UpgradeX       (ux),
        .UpgradeY       (uy),
        .Upgrade_Size   (usize),
        .upgrade_visible(uvis),
        .upgrade_clear  (uclr),
        .pickup_count   (ucnt)
    );

    upgrade_spawner #(.X_MIN(700)) dut2 (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .was_collected  (was_collected2),
        .UpgradeX       (ux2),
        .UpgradeY       (uy2),
        .Upgrade_Size   (usize2),
        .upgrade_visible(uvis2),
        .upgrade_clear  (uclr2),
        .pickup_count   (ucnt2)
    );

    function automatic logic [15:0] model_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Reference LFSR, free-running like the design's.
    logic [15:0] m_lfsr;
    always @(posedge frame_clk or posedge Reset) begin
        if (Reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= model_step(m_lfsr);
    end

    // Edge counter since reset release, and first-visible capture for dut2.
    int   edge_n;
    int   first_vis2 = -1;
    int   x2_at = 0, y2_at = 0;
    logic seen2 = 1'b0;
    always @(posedge frame_clk or posedge Reset) begin
        if (Reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end
    always @(negedge frame_clk) begin
        if (!Reset && !seen2 && uvis2 === 1'b1) begin
            seen2      <= 1'b1;
            first_vis2 <= edge_n;
            x2_at      <= int'(ux2);
            y2_at      <= int'(uy2);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge frame_clk);
        #1;
    endtask

    // Predict placement latency and position from the PICK-entry LFSR value.
    task automatic predict(input logic [15:0] l_in, output int lat, output int ex, output int ey);
        logic [15:0] l;
        int cx, cy;
        bit found;
        l = l_in; found = 1'b0; lat = MAXT; ex = 320; ey = 240;
        for (int t = 0; t < MAXT; t++) begin
            if (!found) begin
                cx = int'(l[9:0]);
                cy = int'(l[15:7]);
                if (cx >= 16 && cx <= 623 && cy >= 16 && cy <= 463) begin
                    found = 1'b1; lat = t + 1; ex = cx; ey = cy;
                end
                l = model_step(l);
            end
        end
    endtask

    // From WAIT with `quiet` frames left before timer hits 0: check the hidden
    // period, the PICK entry, placement latency and placed position.
    task automatic spawn_check(input int quiet, input string tag, output int sx, output int sy);
        int badq, lat, ex, ey, n;
        badq = 0;
        for (int i = 0; i < quiet; i++) begin
            tick;
            if (uvis !== 1'b0 || ux !== 10'd1000 || uy !== 10'd1000 || uclr !== 1'b0) badq++;
        end
        tick;
        if (uvis !== 1'b0 || ux !== 10'd1000 || uy !== 10'd1000 || uclr !== 1'b0) badq++;
        check({tag, " hidden frames"}, badq, 0);
        predict(m_lfsr, lat, ex, ey);
        n = 0;
        while (uvis !== 1'b1 && n < MAXT + 2) begin
            tick;
            n++;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " x"}, int'(ux), ex);
        check({tag, " y"}, int'(uy), ey);
        check({tag, " legal"}, int'((ux >= 10'd16 && ux <= 10'd623 && uy >= 10'd16 && uy <= 10'd463) ||
                                    (ux == 10'd320 && uy == 10'd240)), 1);
        sx = int'(ux);
        sy = int'(uy);
    endtask

    typedef struct {
        logic coll;
        int   vis;
        int   clr;
        int   parked;
        int   cnt;
    } row_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t tbl[6];
        int fx, fy, sx, sy, rx, ry, bq;

        // Collection sequence starting in ACTIVE with count 0.
        tbl[0] = '{1'b0, 1, 0, 0, 0};
        tbl[1] = '{1'b0, 1, 0, 0, 0};
        tbl[2] = '{1'b1, 0, 1, 1, 1};   // despawn edge: clear pulse, count 0->1
        tbl[3] = '{1'b0, 0, 0, 1, 1};   // clear lasts one frame only
        tbl[4] = '{1'b1, 0, 0, 1, 1};   // ignored in WAIT
        tbl[5] = '{1'b0, 0, 0, 1, 1};

        repeat (3) tick;
        check("rst visible", int'(uvis), 0);
        check("rst x", int'(ux), 1000);
        check("rst y", int'(uy), 1000);
        check("rst clear", int'(uclr), 0);
        check("rst count", int'(ucnt), 0);
        check("size", int'(usize), 4);
        Reset = 1'b0;

        spawn_check(299, "first", fx, fy);

        for (int i = 0; i < 6; i++) begin
            was_collected = tbl[i].coll;
            tick;
            check($sformatf("row%0d vis", i), int'(uvis), tbl[i].vis);
            check($sformatf("row%0d clear", i), int'(uclr), tbl[i].clr);
            check($sformatf("row%0d parked", i), int'(ux == 10'd1000 && uy == 10'd1000), tbl[i].parked);
            check($sformatf("row%0d count", i), int'(ucnt), tbl[i].cnt);
        end
        was_collected = 1'b0;

        spawn_check(296, "respawn", sx, sy);

        // Expiry: visible for exactly 600 frames including the placement frame.
        bq = 0;
        for (int i = 0; i < 599; i++) begin
            tick;
            if (uvis !== 1'b1 || uclr !== 1'b0) bq++;
        end
        check("lifetime frames", bq, 0);
        tick;
        check("expire vis", int'(uvis), 0);
        check("expire clear", int'(uclr), 1);
        check("expire x", int'(ux), 1000);
        check("expire count", int'(ucnt), 1);

        spawn_check(299, "post expiry", sx, sy);

        // Collection on the expiry frame counts as a collection.
        repeat (599) tick;
        was_collected = 1'b1;
        tick;
        was_collected = 1'b0;
        check("tie vis", int'(uvis), 0);
        check("tie clear", int'(uclr), 1);
        check("tie count", int'(ucnt), 2);
        tick;
        check("tie clear drop", int'(uclr), 0);

        check("alt seen", int'(seen2), 1);
        check("alt edge", first_vis2, 308);
        check("alt x", x2_at, 320);
        check("alt y", y2_at, 240);

        spawn_check(298, "post tie", sx, sy);

        for (int k = 3; k <= 5; k++) begin
            was_collected = 1'b1;
            tick;
            was_collected = 1'b0;
            check($sformatf("count to %0d", k), int'(ucnt), k);
            spawn_check(299, $sformatf("round%0d", k), sx, sy);
        end

        // Asynchronous reset in the middle of ACTIVE.
        repeat (3) tick;
        check("pre reset count", int'(ucnt), 5);
        #2;
        Reset = 1'b1;
        #1;
        check("async vis", int'(uvis), 0);
        check("async x", int'(ux), 1000);
        check("async y", int'(uy), 1000);
        check("async count", int'(ucnt), 0);
        check("async clear", int'(uclr), 0);
        repeat (2) tick;
        Reset = 1'b0;

        spawn_check(299, "after reset", rx, ry);
        check("repeat x", rx, fx);
        check("repeat y", ry, fy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/upgrade_spawner.md
Name: upgrade_spawner

Overview:
- Upstream of the upgrade pickup collision stage. Decides when and where the bullet-upgrade pickup appears, and drives UpgradeX/UpgradeY/Upgrade_Size into that stage.
- Despawns the pickup when it is collected or its lifetime expires, then re-arms after a delay.
- Issues a one-frame clear pulse. The top level ORs this pulse into the collision stage's reset so `was_collected` re-arms.
- Clocked once per video frame.

Parameters:
- SPAWN_DELAY, 300, frames from reset or despawn until placement starts (>=1).
- LIFETIME, 600, frames the pickup stays visible if uncollected; 0 = never expires.
- SIZE, 4, value driven on Upgrade_Size.
- X_MIN, 16, minimum legal UpgradeX.
- X_MAX, 623, maximum legal UpgradeX.
- Y_MIN, 16, minimum legal UpgradeY.
- Y_MAX, 463, maximum legal UpgradeY.
- MAX_TRIES, 8, candidate rejections before the centre fallback.
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1.

Ports:
- frame_clk  in  1  frame clock
- Reset  in  1  asynchronous reset, active-high
- was_collected  in  1  latched collected flag from the collision stage
- UpgradeX  out  10  pickup centre X
- UpgradeY  out  10  pickup centre Y
- Upgrade_Size  out  10  constant SIZE
- upgrade_visible  out  1  pickup is drawn and collectable
- upgrade_clear  out  1  one-frame pulse that re-arms the collision stage
- pickup_count  out  8  number of pickups collected, saturating

Behaviour:
- Reset is asynchronous, active-high. Clock is frame_clk. All state is registered on the rising frame_clk edge.
- Reset values:
  - state=WAIT, timer=SPAWN_DELAY-1
  - UpgradeX=UpgradeY=10'd1000 (parked), upgrade_visible=0, upgrade_clear=0, pickup_count=0
  - lfsr=SEED, tries=0
- Parking: whenever the pickup is not visible, UpgradeX/UpgradeY=1000. This keeps the collision window off-screen, so no false collisions occur.
- LFSR: 16-bit Galois, taps mask 16'hB400, shifts right every frame in every state. It never reaches 0.
- Candidate position from the current lfsr value:
  - cx = lfsr[9:0]
  - cy = {1'b0, lfsr[15:7]}
  - The candidate is valid iff X_MIN<=cx<=X_MAX and Y_MIN<=cy<=Y_MAX (unsigned compares).
- State WAIT:
  - If timer==0, go to PICK with tries=0; otherwise decrement timer.
  - WAIT therefore lasts exactly SPAWN_DELAY frames.
  - was_collected is ignored.
- State PICK (one candidate per frame):
  - Valid candidate: latch UpgradeX=cx, UpgradeY=cy; go to ACTIVE; upgrade_visible=1; timer=LIFETIME-1.
  - Invalid and tries==MAX_TRIES-1: latch the centre (320,240) and go to ACTIVE as above.
  - Otherwise: increment tries and stay in PICK.
  - Placement latency is 1 to MAX_TRIES frames.
- State ACTIVE:
  - If was_collected==1: despawn, and pickup_count increments unless it is already 255.
  - Else if LIFETIME!=0 and timer==0: despawn (expiry).
  - Otherwise: if LIFETIME!=0, decrement timer.
  - Collection has priority over expiry when both occur in the same frame.
- Despawn (a single registered edge):
  - upgrade_visible=0, position parked, upgrade_clear=1.
  - state=WAIT, timer=SPAWN_DELAY-1.
- upgrade_clear is high for exactly one frame (the first WAIT frame) and is 0 on every other frame.
- Reset asserted mid-operation (any state) returns the block to the reset values immediately. pickup_count is also cleared.
- Upgrade_Size is tied to SIZE and is unaffected by reset.

Test Plan:
- Reset, then hold 299 frames -> state WAIT, upgrade_visible=0, UpgradeX=UpgradeY=1000, upgrade_clear=0 throughout. PICK is entered at frame 300; visible goes high within 8 further frames, with X in [16,623] and Y in [16,463] or equal to (320,240).
- ACTIVE, then pulse was_collected high for 1 frame -> the next edge gives visible=0, parked position, upgrade_clear high for exactly 1 frame, pickup_count 0->1. Respawn follows 300 frames later.
- LIFETIME=600 with no collection -> visible for exactly 600 frames, then a despawn with upgrade_clear pulse; pickup_count unchanged.
- Expiry frame coincides with was_collected=1 -> treated as a collection: pickup_count increments, single clear pulse.
- Override X_MIN=700 (nothing valid) -> after exactly 8 PICK frames, UpgradeX=320, UpgradeY=240, visible=1.
- Assert Reset mid-ACTIVE with pickup_count=5 -> outputs return asynchronously to reset values (visible=0, parked position, count=0). Release, and the pickup is placed again after the SPAWN_DELAY WAIT plus 1–MAX_TRIES PICK frames, at the same position as after the first reset.
